// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - memory-mapped machine timer on the dmem valid/ready bus
//
// Purpose: 64-bit free-running mtime with a prescaler, a 64-bit mtimecmp and a
// control register, served as a responder on the data-memory bus. irq_o is a
// registered level output that is high while mtime >= mtimecmp.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   valid_i  request valid, held by the initiator until ready_o
//   ready_o  one-cycle response strobe; rdata_o valid while high
//   addr_i   byte address, only [4:2] decoded
//   wdata_i  write data
//   we_i     byte write enables, 4'b0000 = read
//   rdata_o  read data, held until the next read response
//   irq_o    timer interrupt (level)
//
// Register map (addr_i[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO,
// 3 MTIMECMP_HI, 4 CTRL (bit0 EN, bits[15:8] PRESC), 5-7 unmapped.

module dmem_timer #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic [3:0]            we_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  irq_o
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t      state, state_nxt;

  logic [63:0] mtime, mtime_nxt;
  logic [63:0] mtimecmp, mtimecmp_nxt;
  logic        en, en_nxt;
  logic [7:0]  presc, presc_nxt;
  logic [7:0]  presc_cnt, presc_cnt_nxt;
  logic [31:0] hi_shadow, hi_shadow_nxt;
  logic [31:0] rdata, rdata_nxt;
  logic        irq;

  logic        accept, wr, rd, tick;
  logic [2:0]  idx;
  logic [31:0] rd_val;

  // Address bits outside [4:2] are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return r;
  endfunction

  assign idx    = addr_i[4:2];
  assign accept = (state == S_IDLE) && valid_i;
  assign wr     = accept && (we_i != 4'b0000);
  assign rd     = accept && (we_i == 4'b0000);
  assign tick   = en && (presc_cnt == presc);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; RESP always lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (valid_i) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_o = (state == S_RESP);
  end

  // Read mux uses the pre-update register values of the accepting edge
  always_comb begin
    rd_val = 32'h0;
    case (idx)
      3'd0: rd_val = mtime[31:0];
      3'd1: rd_val = hi_shadow;
      3'd2: rd_val = mtimecmp[31:0];
      3'd3: rd_val = mtimecmp[63:32];
      3'd4: rd_val = {16'h0, presc, 7'h0, en};
      default: rd_val = 32'h0;
    endcase
  end

  always_comb begin
    mtime_nxt     = mtime;
    mtimecmp_nxt  = mtimecmp;
    en_nxt        = en;
    presc_nxt     = presc;
    presc_cnt_nxt = presc_cnt;
    hi_shadow_nxt = hi_shadow;
    rdata_nxt     = rdata;

    // Software writes to mtime take priority over the tick increment.
    if (wr && idx == 3'd0) begin
      mtime_nxt[31:0] = merge(mtime[31:0], wdata_i[31:0], we_i);
    end else if (wr && idx == 3'd1) begin
      mtime_nxt[63:32] = merge(mtime[63:32], wdata_i[31:0], we_i);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end

    if (wr && idx == 3'd2) begin
      mtimecmp_nxt[31:0] = merge(mtimecmp[31:0], wdata_i[31:0], we_i);
    end
    if (wr && idx == 3'd3) begin
      mtimecmp_nxt[63:32] = merge(mtimecmp[63:32], wdata_i[31:0], we_i);
    end

    if (wr && idx == 3'd4) begin
      if (we_i[0]) en_nxt    = wdata_i[0];
      if (we_i[1]) presc_nxt = wdata_i[15:8];
      presc_cnt_nxt = 8'h0;
    end else if (en) begin
      presc_cnt_nxt = tick ? 8'h0 : presc_cnt + 8'h1;
    end

    if (rd) begin
      rdata_nxt = rd_val;
      // Shadow the high word together with the low word for atomic 64-bit reads
      if (idx == 3'd0) hi_shadow_nxt = mtime[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime     <= 64'h0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      en        <= 1'b0;
      presc     <= 8'h0;
      presc_cnt <= 8'h0;
      hi_shadow <= 32'h0;
      rdata     <= 32'h0;
      irq       <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= mtimecmp_nxt;
      en        <= en_nxt;
      presc     <= presc_nxt;
      presc_cnt <= presc_cnt_nxt;
      hi_shadow <= hi_shadow_nxt;
      rdata     <= rdata_nxt;
      irq       <= (mtime >= mtimecmp);
    end
  end

  assign rdata_o = rdata;
  assign irq_o   = irq;

endmodule

// File: tb/tb_dmem_timer.sv
// tb/tb_dmem_timer.sv - self-checking bench for dmem_timer

module tb_dmem_timer;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  we_i;
  logic [31:0] rdata_o;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  dmem_timer #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .we_i    (we_i),
    .rdata_o (rdata_o),
    .irq_o   (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          chk;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One bus transfer: drive at a negedge, accepted at the next posedge,
  // ready_o must be high at the following negedge.
  task automatic xfer(input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    valid_i = 1'b1;
    addr_i  = a;
    we_i    = w;
    wdata_i = d;
    @(negedge clk);
    check("ready_latency", {31'h0, ready_o}, 32'h1);
    rd      = rdata_o;
    valid_i = 1'b0;
    we_i    = 4'h0;
  endtask

  logic [31:0] rd, v1, v2, lo, hi;
  int          n;
  logic        cur_ctrl;

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    we_i    = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, ready_o}, 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_irq", {31'h0, irq_o}, 32'h0);
    rst_n = 1'b1;

    // Register access vectors (counter disabled throughout)
    vecs[0]  = '{32'h10,  4'h0, 32'h0,         32'h0,         1};
    vecs[1]  = '{32'h0C,  4'h0, 32'h0,         32'hFFFF_FFFF, 1};
    vecs[2]  = '{32'h08,  4'h0, 32'h0,         32'hFFFF_FFFF, 1};
    vecs[3]  = '{32'h00,  4'h0, 32'h0,         32'h0,         1};
    vecs[4]  = '{32'h04,  4'h0, 32'h0,         32'h0,         1};
    vecs[5]  = '{32'h08,  4'h2, 32'hAABB_CCDD, 32'h0,         0};
    vecs[6]  = '{32'h08,  4'h0, 32'h0,         32'hFFFF_CCFF, 1};
    vecs[7]  = '{32'h18,  4'hF, 32'h1234_5678, 32'h0,         0};
    vecs[8]  = '{32'h18,  4'h0, 32'h0,         32'h0,         1};
    vecs[9]  = '{32'h10B, 4'h0, 32'h0,         32'hFFFF_CCFF, 1};
    vecs[10] = '{32'h10,  4'hF, 32'hFFFF_FFFE, 32'h0,         0};
    vecs[11] = '{32'h10,  4'h0, 32'h0,         32'h0000_FF00, 1};
    vecs[12] = '{32'h10,  4'hF, 32'h0,         32'h0,         0};
    vecs[13] = '{32'h08,  4'hF, 32'hFFFF_FFFF, 32'h0,         0};
    vecs[14] = '{32'h08,  4'h0, 32'h0,         32'hFFFF_FFFF, 1};
    vecs[15] = '{32'h00,  4'h0, 32'h0,         32'h0,         1};

    for (int i = 0; i < 16; i++) begin
      xfer(vecs[i].addr, vecs[i].we, vecs[i].wdata, rd);
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    check("irq_idle", {31'h0, irq_o}, 32'h0);

    // Prescaled counting: PRESC=3 gives a tick every 4 cycles
    xfer(32'h10, 4'hF, 32'h0000_0301, rd);
    repeat (40) @(negedge clk);
    xfer(32'h00, 4'h0, 32'h0, v1);
    checks++;
    if (v1 < 32'd9 || v1 > 32'd11) begin
      errors++;
      $display("FAIL presc_count: got %0d expected 10+-1", v1);
    end
    xfer(32'h10, 4'hF, 32'h0, rd);
    xfer(32'h00, 4'h0, 32'h0, v1);
    repeat (20) @(negedge clk);
    xfer(32'h00, 4'h0, 32'h0, v2);
    check("frozen", v2, v1);

    // Atomic 64-bit read across the low-word wrap
    xfer(32'h00, 4'hF, 32'hFFFF_FFFF, rd);
    xfer(32'h04, 4'hF, 32'h0000_0001, rd);
    xfer(32'h10, 4'hF, 32'h0000_0001, rd);
    xfer(32'h00, 4'h0, 32'h0, lo);
    xfer(32'h04, 4'h0, 32'h0, hi);
    check("shadow_hi", hi, (lo == 32'hFFFF_FFFF) ? 32'h1 : 32'h2);
    check("wrap_lo", lo, 32'h0);
    xfer(32'h10, 4'hF, 32'h0, rd);

    // Interrupt: mtime 100 -> 105 with PRESC=0
    xfer(32'h00, 4'hF, 32'd100, rd);
    xfer(32'h04, 4'hF, 32'h0, rd);
    xfer(32'h0C, 4'hF, 32'h0, rd);
    xfer(32'h08, 4'hF, 32'd105, rd);
    check("irq_below", {31'h0, irq_o}, 32'h0);
    xfer(32'h10, 4'hF, 32'h0000_0001, rd);
    n = 0;
    while (!irq_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("irq_rise_cycles", n, 6);
    xfer(32'h0C, 4'hF, 32'hFFFF_FFFF, rd);
    @(negedge clk);
    check("irq_fall", {31'h0, irq_o}, 32'h0);
    xfer(32'h10, 4'hF, 32'h0, rd);

    // Continuous valid: ready_o alternates 0,1,0,1 and reads alternate
    @(negedge clk);
    valid_i  = 1'b1;
    we_i     = 4'h0;
    addr_i   = 32'h10;
    cur_ctrl = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b_ready%0d", k), {31'h0, ready_o}, (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k % 2 == 1) begin
        check($sformatf("b2b_rdata%0d", k), rdata_o, cur_ctrl ? 32'h0 : 32'hFFFF_FFFF);
        cur_ctrl = ~cur_ctrl;
        addr_i   = cur_ctrl ? 32'h10 : 32'h0C;
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    @(negedge clk);

    // Reset during RESP drops the transfer and restores reset values
    xfer(32'h08, 4'hF, 32'd5, rd);
    xfer(32'h10, 4'hF, 32'h0000_0001, rd);
    @(negedge clk);
    valid_i = 1'b1;
    addr_i  = 32'h00;
    we_i    = 4'h0;
    @(negedge clk);
    check("pre_reset_ready", {31'h0, ready_o}, 32'h1);
    rst_n   = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("reset_resp_ready", {31'h0, ready_o}, 32'h0);
    check("reset_resp_rdata", rdata_o, 32'h0);
    check("reset_resp_irq", {31'h0, irq_o}, 32'h0);
    rst_n = 1'b1;
    xfer(32'h08, 4'h0, 32'h0, rd);
    check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    xfer(32'h10, 4'h0, 32'h0, rd);
    check("rst_ctrl", rd, 32'h0);
    xfer(32'h00, 4'h0, 32'h0, rd);
    check("rst_mtime_lo", rd, 32'h0);
    xfer(32'h04, 4'h0, 32'h0, rd);
    check("rst_shadow", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
